// File: rtl/defines.sv
// Shared definitions for the operand fetch stage: operand-source enums and
// the default lane-vector types. OF_NUM_LANES sets the default lane count.
`ifndef OF_NUM_LANES
`define OF_NUM_LANES 16
`endif

package defines;

  localparam int LANES_DEFAULT = `OF_NUM_LANES;

  typedef logic [32*LANES_DEFAULT-1:0] lane_vec_t;
  typedef logic [LANES_DEFAULT-1:0]    lane_mask_t;

  // Source of operand2; the unused encoding 3 behaves like OP2_SCALAR2.
  typedef enum logic [1:0] {
    OP2_SCALAR2 = 2'd0,
    OP2_VECTOR2 = 2'd1,
    OP2_IMM     = 2'd2
  } op2_src_t;

  // Source of the lane mask; the unused encoding 3 behaves like MASK_ALL_ONES.
  typedef enum logic [1:0] {
    MASK_SCALAR1  = 2'd0,
    MASK_SCALAR2  = 2'd1,
    MASK_ALL_ONES = 2'd2
  } mask_src_t;

endpackage

// File: rtl/of_regfile_bank.sv
// Two-read / one-write register bank with registered (synchronous) reads.
// Read data is only updated when its enable is high, so it holds the last
// read while the stage is stalled. A read and a write to the same address at
// the same edge return the old contents. Storage has no reset; the read
// registers reset to zero so the stage outputs come up clean.
module of_regfile_bank
  import defines::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  SIZE       = 128,
  localparam int ADDR_WIDTH = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd1_en,
  input  logic [ADDR_WIDTH-1:0] rd1_addr,
  output logic [DATA_WIDTH-1:0] rd1_data,
  input  logic                  rd2_en,
  input  logic [ADDR_WIDTH-1:0] rd2_addr,
  output logic [DATA_WIDTH-1:0] rd2_data,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [DATA_WIDTH-1:0] mem [SIZE];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read ports, held while their enable is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd1_data <= '0;
      rd2_data <= '0;
    end else begin
      if (rd1_en) rd1_data <= mem[rd1_addr];
      if (rd2_en) rd2_data <= mem[rd2_addr];
    end
  end

endmodule

// File: rtl/operand_fetch_pipe.sv
// Operand fetch stage: per-thread scalar and vector register files, operand
// muxing and a registered, stallable output.
// Optional feature macro OF_BYPASS_EN: forwards writeback data into operands
// being read in the same cycle and into a held (stalled) output.
//
// Handshake: a transfer happens on an edge where valid && ready are both high.
// ts_ready = !of_valid || of_ready, so the input side never depends on
// ts_valid. Once of_valid is high the of_* payload stays stable until it is
// taken (of_ready), rolled back, or reset; with OF_BYPASS_EN a held payload
// may still absorb matching writebacks.
module operand_fetch_pipe
  import defines::*;
#(
  parameter int  NUM_THREADS = 4,
  parameter int  NUM_LANES   = LANES_DEFAULT,
  parameter int  NUM_REGS    = 32,
  parameter int  INSTR_W     = 64,
  localparam int TW          = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
  localparam int RW          = $clog2(NUM_REGS),
  localparam int VW          = 32 * NUM_LANES
) (
  input  logic               clk,
  input  logic               reset,
  // thread select side
  input  logic               ts_valid,
  output logic               ts_ready,
  input  logic [TW-1:0]      ts_thread_idx,
  input  logic [INSTR_W-1:0] ts_instr,
  input  logic [RW-1:0]      ts_s1_sel,
  input  logic [RW-1:0]      ts_s2_sel,
  input  logic [RW-1:0]      ts_v1_sel,
  input  logic [RW-1:0]      ts_v2_sel,
  input  logic               ts_op1_vec,
  input  logic [1:0]         ts_op2_src,
  input  logic [1:0]         ts_mask_src,
  input  logic [31:0]        ts_imm,
  input  logic               ts_store_vec,
  // execute side
  output logic               of_valid,
  input  logic               of_ready,
  output logic [TW-1:0]      of_thread_idx,
  output logic [INSTR_W-1:0] of_instr,
  output logic [VW-1:0]      of_operand1,
  output logic [VW-1:0]      of_operand2,
  output logic [VW-1:0]      of_store_value,
  output logic [NUM_LANES-1:0] of_mask,
  // writeback
  input  logic               wb_en,
  input  logic               wb_vector,
  input  logic [TW-1:0]      wb_thread_idx,
  input  logic [RW-1:0]      wb_reg,
  input  logic [VW-1:0]      wb_value,
  input  logic [NUM_LANES-1:0] wb_mask,
  // rollback
  input  logic               rollback_en,
  input  logic [TW-1:0]      rollback_thread_idx
);

  // With one thread the thread index carries no address bits.
  localparam int AW   = (NUM_THREADS > 1) ? TW + RW : RW;
  localparam int SIZE = NUM_REGS * NUM_THREADS;

  logic          accept;
  logic          rb_out;
  logic [AW-1:0] s1_addr, s2_addr, v1_addr, v2_addr, wb_addr;
  logic [31:0]   bank_s1, bank_s2;
  logic [VW-1:0] bank_v1, bank_v2;
  logic [31:0]   raw_s1, raw_s2;
  logic [VW-1:0] raw_v1, raw_v2;

  logic          op1_vec_q;
  op2_src_t      op2_src_q;
  mask_src_t     mask_src_q;
  logic [31:0]   imm_q;
  logic          store_vec_q;

  assign ts_ready = !of_valid || of_ready;
  assign accept   = ts_valid && ts_ready
                    && !(rollback_en && (rollback_thread_idx == ts_thread_idx));
  assign rb_out   = rollback_en && (rollback_thread_idx == of_thread_idx);

  assign s1_addr = AW'({ts_thread_idx, ts_s1_sel});
  assign s2_addr = AW'({ts_thread_idx, ts_s2_sel});
  assign v1_addr = AW'({ts_thread_idx, ts_v1_sel});
  assign v2_addr = AW'({ts_thread_idx, ts_v2_sel});
  assign wb_addr = AW'({wb_thread_idx, wb_reg});

  of_regfile_bank #(.DATA_WIDTH(32), .SIZE(SIZE)) u_sbank (
    .clk      (clk),
    .reset    (reset),
    .rd1_en   (accept),
    .rd1_addr (s1_addr),
    .rd1_data (bank_s1),
    .rd2_en   (accept),
    .rd2_addr (s2_addr),
    .rd2_data (bank_s2),
    .wr_en    (wb_en && !wb_vector),
    .wr_addr  (wb_addr),
    .wr_data  (wb_value[31:0])
  );

  // One bank per lane; mask bit NUM_LANES-1-l enables lane l.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_vlane
    of_regfile_bank #(.DATA_WIDTH(32), .SIZE(SIZE)) u_vbank (
      .clk      (clk),
      .reset    (reset),
      .rd1_en   (accept),
      .rd1_addr (v1_addr),
      .rd1_data (bank_v1[32*l +: 32]),
      .rd2_en   (accept),
      .rd2_addr (v2_addr),
      .rd2_data (bank_v2[32*l +: 32]),
      .wr_en    (wb_en && wb_vector && wb_mask[NUM_LANES-1-l]),
      .wr_addr  (wb_addr),
      .wr_data  (wb_value[32*l +: 32])
    );
  end

  // Output valid: new accept wins over drain and rollback of the held entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      of_valid <= 1'b0;
    end else if (accept) begin
      of_valid <= 1'b1;
    end else if (of_valid && (of_ready || rb_out)) begin
      of_valid <= 1'b0;
    end
  end

  // Payload and operand-mux controls, captured only on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      of_thread_idx <= '0;
      of_instr      <= '0;
      op1_vec_q     <= 1'b0;
      op2_src_q     <= OP2_SCALAR2;
      mask_src_q    <= MASK_SCALAR1;
      imm_q         <= '0;
      store_vec_q   <= 1'b0;
    end else if (accept) begin
      of_thread_idx <= ts_thread_idx;
      of_instr      <= ts_instr;
      op1_vec_q     <= ts_op1_vec;
      op2_src_q     <= op2_src_t'(ts_op2_src);
      mask_src_q    <= mask_src_t'(ts_mask_src);
      imm_q         <= ts_imm;
      store_vec_q   <= ts_store_vec;
    end
  end

`ifdef OF_BYPASS_EN
  // Forwarding keeps its own per-operand override registers; a set valid bit
  // replaces the bank read data for that operand (or lane).
  logic [RW-1:0]        s1_sel_q, s2_sel_q, v1_sel_q, v2_sel_q;
  logic [TW-1:0]        tgt_thread;
  logic [RW-1:0]        tgt_s1, tgt_s2, tgt_v1, tgt_v2;
  logic                 s1_hit, s2_hit;
  logic [NUM_LANES-1:0] v1_hit, v2_hit;
  logic                 fwd_s1_v, fwd_s2_v;
  logic [31:0]          fwd_s1_d, fwd_s2_d;
  logic [NUM_LANES-1:0] fwd_v1_v, fwd_v2_v;
  logic [VW-1:0]        fwd_v1_d, fwd_v2_d;

  assign tgt_thread = accept ? ts_thread_idx : of_thread_idx;
  assign tgt_s1     = accept ? ts_s1_sel : s1_sel_q;
  assign tgt_s2     = accept ? ts_s2_sel : s2_sel_q;
  assign tgt_v1     = accept ? ts_v1_sel : v1_sel_q;
  assign tgt_v2     = accept ? ts_v2_sel : v2_sel_q;

  // Writeback hits against the operands being read or held.
  always_comb begin
    s1_hit = wb_en && !wb_vector && (wb_thread_idx == tgt_thread) && (wb_reg == tgt_s1);
    s2_hit = wb_en && !wb_vector && (wb_thread_idx == tgt_thread) && (wb_reg == tgt_s2);
    v1_hit = '0;
    v2_hit = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      v1_hit[l] = wb_en && wb_vector && wb_mask[NUM_LANES-1-l]
                  && (wb_thread_idx == tgt_thread) && (wb_reg == tgt_v1);
      v2_hit[l] = wb_en && wb_vector && wb_mask[NUM_LANES-1-l]
                  && (wb_thread_idx == tgt_thread) && (wb_reg == tgt_v2);
    end
  end

  // Override registers: reloaded on accept, accumulated while holding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_sel_q <= '0;
      s2_sel_q <= '0;
      v1_sel_q <= '0;
      v2_sel_q <= '0;
      fwd_s1_v <= 1'b0;
      fwd_s2_v <= 1'b0;
      fwd_s1_d <= '0;
      fwd_s2_d <= '0;
      fwd_v1_v <= '0;
      fwd_v2_v <= '0;
      fwd_v1_d <= '0;
      fwd_v2_d <= '0;
    end else if (accept) begin
      s1_sel_q <= ts_s1_sel;
      s2_sel_q <= ts_s2_sel;
      v1_sel_q <= ts_v1_sel;
      v2_sel_q <= ts_v2_sel;
      fwd_s1_v <= s1_hit;
      fwd_s2_v <= s2_hit;
      fwd_s1_d <= wb_value[31:0];
      fwd_s2_d <= wb_value[31:0];
      fwd_v1_v <= v1_hit;
      fwd_v2_v <= v2_hit;
      fwd_v1_d <= wb_value;
      fwd_v2_d <= wb_value;
    end else if (of_valid) begin
      if (s1_hit) begin
        fwd_s1_v <= 1'b1;
        fwd_s1_d <= wb_value[31:0];
      end
      if (s2_hit) begin
        fwd_s2_v <= 1'b1;
        fwd_s2_d <= wb_value[31:0];
      end
      fwd_v1_v <= fwd_v1_v | v1_hit;
      fwd_v2_v <= fwd_v2_v | v2_hit;
      for (int l = 0; l < NUM_LANES; l++) begin
        if (v1_hit[l]) fwd_v1_d[32*l +: 32] <= wb_value[32*l +: 32];
        if (v2_hit[l]) fwd_v2_d[32*l +: 32] <= wb_value[32*l +: 32];
      end
    end
  end

  // Effective operands: override where forwarded, bank data elsewhere.
  always_comb begin
    raw_s1 = fwd_s1_v ? fwd_s1_d : bank_s1;
    raw_s2 = fwd_s2_v ? fwd_s2_d : bank_s2;
    raw_v1 = bank_v1;
    raw_v2 = bank_v2;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (fwd_v1_v[l]) raw_v1[32*l +: 32] = fwd_v1_d[32*l +: 32];
      if (fwd_v2_v[l]) raw_v2[32*l +: 32] = fwd_v2_d[32*l +: 32];
    end
  end
`else
  // Effective operands are the bank reads as captured on accept.
  always_comb begin
    raw_s1 = bank_s1;
    raw_s2 = bank_s2;
    raw_v1 = bank_v1;
    raw_v2 = bank_v2;
  end
`endif

  // Operand, mask and store-value formation from the captured reads.
  always_comb begin
    of_operand1    = '0;
    of_operand2    = '0;
    of_store_value = '0;
    of_mask        = '1;
    for (int l = 0; l < NUM_LANES; l++) begin
      of_operand1[32*l +: 32] = op1_vec_q ? raw_v1[32*l +: 32] : raw_s1;
      case (op2_src_q)
        OP2_VECTOR2: of_operand2[32*l +: 32] = raw_v2[32*l +: 32];
        OP2_IMM:     of_operand2[32*l +: 32] = imm_q;
        default:     of_operand2[32*l +: 32] = raw_s2;
      endcase
      if (store_vec_q) begin
        of_store_value[32*l +: 32] = raw_v2[32*l +: 32];
      end else if (l == NUM_LANES - 1) begin
        of_store_value[32*l +: 32] = raw_s2;
      end
    end
    case (mask_src_q)
      MASK_SCALAR1: of_mask = raw_s1[NUM_LANES-1:0];
      MASK_SCALAR2: of_mask = raw_s2[NUM_LANES-1:0];
      default:      of_mask = '1;
    endcase
  end

endmodule

// File: doc/operand_fetch_pipe.md
# operand_fetch_pipe

Parametrised operand fetch stage for the Nyuzi core pipeline, placed between thread select and the execute/dcache-tag stages. It holds per-thread scalar and vector register files, reads operands for one instruction per accepted cycle, and forms operand1, operand2, mask and store value. Unlike the fixed-configuration stage, it has a registered, stallable valid/ready output. It also supports optional writeback-to-read forwarding, including into a held (stalled) output.

## Interface
- NUM_THREADS, 4, hardware threads (power of 2, ≥1)
- NUM_LANES, 16, vector lanes (≤32)
- NUM_REGS, 32, architectural registers per file (power of 2)
- INSTR_W, 64, opaque decoded-instruction sideband width
- TW = max(1,$clog2(NUM_THREADS)); RW = $clog2(NUM_REGS) (derived)

Ports. Reset is asynchronous and active-high on `reset`; the clock is `clk`.
- clk  in  1  clock
- reset  in  1  async active-high reset
- ts_valid  in  1  instruction offered
- ts_ready  out  1  stage can accept
- ts_thread_idx  in  TW  thread
- ts_instr  in  INSTR_W  sideband, passed through
- ts_s1_sel / ts_s2_sel / ts_v1_sel / ts_v2_sel  in  RW each  register selects
- ts_op1_vec  in  1  op1 = vector1 (else scalar1 broadcast)
- ts_op2_src  in  2  0 scalar2, 1 vector2, 2 immediate
- ts_mask_src  in  2  0 scalar1, 1 scalar2, 2 all-ones
- ts_imm  in  32  immediate
- ts_store_vec  in  1  store value = vector2 (else scalar2 in lane NUM_LANES-1, zeros elsewhere)
- of_valid  out  1  output valid
- of_ready  in  1  downstream accepts
- of_thread_idx  out  TW; of_instr  out  INSTR_W
- of_operand1, of_operand2, of_store_value  out  32*NUM_LANES
- of_mask  out  NUM_LANES
- wb_en, wb_vector  in  1 each
- wb_thread_idx  in  TW; wb_reg  in  RW
- wb_value  in  32*NUM_LANES; wb_mask  in  NUM_LANES
- rollback_en  in  1; rollback_thread_idx  in  TW

## Operation
- ts_ready = !of_valid || of_ready.
- accept = ts_valid && ts_ready && !(rollback_en && rollback_thread_idx == ts_thread_idx).
- On accept: register files are read at {ts_thread_idx, sel}, operands are muxed, and all of_* are registered.
- Scalar write: wb_en && !wb_vector. Writes wb_value lane 0 (bits 31:0) to {wb_thread_idx, wb_reg}.
- Vector write: lane L is written when wb_en && wb_vector && wb_mask[NUM_LANES-1-L]. MSB of the mask is lane 0.
- Mask from a scalar uses bits [NUM_LANES-1:0] of that scalar.
- Lane L occupies bits [32*L+31:32*L].
- Rollback also clears of_valid next cycle when of_valid && rollback_thread_idx == of_thread_idx, regardless of of_ready.
- Held output (of_valid && !of_ready) keeps all data stable, except for forwarding as defined under Configuration.

## Timing
- Latency: 1 cycle from accept to of_valid.
- Full throughput when of_ready is held high.
- Reset: of_valid = 0. All data outputs, of_thread_idx and of_instr = 0.
- Register file contents are undefined after reset.
- If of_valid && of_ready && !accept, then of_valid = 0 next cycle.
- If accept and rollback of the held output happen together, the new instruction wins (of_valid = 1).
- A write lands at the clock edge and is readable by an accept one cycle later.
- Reset mid-stall drops the held instruction.

## Configuration
- OF_BYPASS_EN defined:
  - A same-cycle write matching the read thread and register is forwarded into the accepted operands, per lane under the vector mask.
  - A write matching a held output's thread/register updates the held operand lanes, and the mask/store value derived from them.
- OF_BYPASS_EN undefined:
  - A same-cycle read returns the old value.
  - Held outputs never change.
  - The scheduler must guarantee a one-cycle write-to-read gap.

## Structure
- Shared package `defines` holds:
  - op2_src_t and mask_src_t enums
  - lane-vector typedef parametrised through NUM_LANES macros
- Sub-module `of_regfile_bank`: a 2-read/1-write bank, DATA_WIDTH=32, SIZE=NUM_REGS*NUM_THREADS, synchronous read on enable.
  - One instance for scalars; NUM_LANES instances for vectors.
  - Forwarding logic lives in the top module.

## Test plan
- Write scalar t2 r5 = 0x1234. Two cycles later, accept a read of s1=r5 with op1 scalar, op2 immediate 7, mask all-ones. Required response:
  - operand1 = 0x1234 in every lane
  - operand2 = 7 in every lane
  - of_mask = all ones
- Vector write t0 r3 with lanes = lane index, wb_mask = 0xAAAA (NUM_LANES=16), over an old value of 0. Then read v2=r3 with ts_store_vec=1. Required: store_value has lanes 0,2,4… = index and the other lanes = 0.
- Hold of_ready=0 for 3 cycles with 2 instructions offered. Required:
  - ts_ready = 0 during the hold
  - outputs remain stable
  - after release, both instructions emerge in order with no loss
- Rollback of t1 while t1 is accepted and t1 is held. Required: neither instruction appears. A t0 instruction in the same cycle is unaffected.
- OF_BYPASS_EN: write r9 = 0xDEAD in the same cycle as a read of r9, and again to a held r9 operand. Required: both show 0xDEAD. Without the macro: the first shows the old value and the held operand is unchanged.
- Assert reset while of_valid=1. Required: of_valid = 0 immediately and all outputs = 0.
